// File: rtl/warp_sched_rr_if.sv
// Fetch-request handshake between the warp scheduler and the instruction fetch stage.
interface warp_sched_rr_if #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4
);
    localparam int NW_BITS = $clog2(NUM_WARPS);

    logic                   req_valid;
    logic                   req_ready;
    logic [NW_BITS-1:0]     req_wid;
    logic [NUM_THREADS-1:0] req_tmask;
    logic [31:0]            req_pc;

    modport master (
        output req_valid,
        output req_wid,
        output req_tmask,
        output req_pc,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_wid,
        input  req_tmask,
        input  req_pc,
        output req_ready
    );
endinterface

// File: rtl/warp_sched_rr.sv
// Warp scheduler: tracks per-warp active/stalled/barrier state, PC and thread
// mask, picks one ready warp per cycle (fixed priority or round-robin) and
// presents it on a registered valid/ready fetch-request port.
module warp_sched_rr #(
    parameter int          NUM_WARPS    = 4,
    parameter int          NUM_THREADS  = 4,
    parameter int          NUM_BARRIERS = 4,
    parameter logic [31:0] STARTUP_ADDR = 32'h80000000,
    parameter int          SCHED_MODE   = 1,
    localparam int         NW_BITS      = $clog2(NUM_WARPS),
    localparam int         NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ctl_valid,
    input  logic [1:0]             ctl_op,
    input  logic [NW_BITS-1:0]     ctl_wid,
    input  logic [NUM_THREADS-1:0] ctl_tmask,
    input  logic [NUM_WARPS-1:0]   ctl_wmask,
    input  logic [31:0]            ctl_pc,
    input  logic [NB_BITS-1:0]     ctl_bar_id,
    input  logic [NW_BITS-1:0]     ctl_bar_size_m1,
    input  logic                   br_valid,
    input  logic [NW_BITS-1:0]     br_wid,
    input  logic                   br_taken,
    input  logic [31:0]            br_dest,
    input  logic                   wstall_valid,
    input  logic [NW_BITS-1:0]     wstall_wid,
    input  logic                   wstall_stalled,
    warp_sched_rr_if.master        req,
    output logic [NUM_WARPS-1:0]   active_warps,
    output logic                   busy
);
    localparam logic [1:0] OP_TMC     = 2'd0;
    localparam logic [1:0] OP_WSPAWN  = 2'd1;
    localparam logic [1:0] OP_BARRIER = 2'd2;

    logic [NUM_WARPS-1:0]   active;
    logic [NUM_WARPS-1:0]   stalled;
    logic [NUM_WARPS-1:0]   bar_mask [NUM_BARRIERS];
    logic [31:0]            pc_r     [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_r  [NUM_WARPS];
    logic [NW_BITS-1:0]     rr_ptr;

    logic [NUM_WARPS-1:0]   bar_any;
    logic [NUM_WARPS-1:0]   ready_p0;
    logic [NW_BITS-1:0]     rr_idx;
    logic [NW_BITS-1:0]     sel_wid_p0;
    logic                   sel_vld_p0;
    logic                   load_p0;
    logic                   grant_p0;
    logic [NW_BITS:0]       bar_cnt;
    logic                   bar_release;

    logic                   vld_p1;
    logic [NW_BITS-1:0]     wid_p1;
    logic [NUM_THREADS-1:0] tmask_p1;
    logic [31:0]            pc_p1;

    function automatic logic [NW_BITS:0] popcount(input logic [NUM_WARPS-1:0] v);
        logic [NW_BITS:0] c;
        c = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            c = c + {{NW_BITS{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Any warp parked at any barrier is excluded from scheduling.
    always_comb begin
        bar_any = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            bar_any = bar_any | bar_mask[b];
        end
    end

    assign ready_p0    = active & ~stalled & ~bar_any;
    assign bar_cnt     = popcount(bar_mask[ctl_bar_id]);
    assign bar_release = (bar_cnt == {1'b0, ctl_bar_size_m1});

    // Pick the next warp: lowest index, or first ready after the RR pointer.
    always_comb begin
        sel_vld_p0 = 1'b0;
        sel_wid_p0 = '0;
        rr_idx     = '0;
        if (SCHED_MODE == 0) begin
            for (int i = NUM_WARPS - 1; i >= 0; i--) begin
                if (ready_p0[i]) begin
                    sel_vld_p0 = 1'b1;
                    sel_wid_p0 = NW_BITS'(i);
                end
            end
        end else begin
            for (int k = NUM_WARPS; k >= 1; k--) begin
                rr_idx = rr_ptr + NW_BITS'(k);
                if (ready_p0[rr_idx]) begin
                    sel_vld_p0 = 1'b1;
                    sel_wid_p0 = rr_idx;
                end
            end
        end
    end

    assign load_p0  = !vld_p1 || req.req_ready;
    assign grant_p0 = load_p0 && sel_vld_p0;

    // Warp state and output register; later writes in this block take precedence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active  <= {{(NUM_WARPS-1){1'b0}}, 1'b1};
            stalled <= '0;
            rr_ptr  <= NW_BITS'(NUM_WARPS - 1);
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                bar_mask[b] <= '0;
            end
            for (int i = 0; i < NUM_WARPS; i++) begin
                pc_r[i]    <= (i == 0) ? STARTUP_ADDR : 32'd0;
                tmask_r[i] <= (i == 0) ? {NUM_THREADS{1'b1}} : {NUM_THREADS{1'b0}};
            end
            vld_p1   <= 1'b0;
            wid_p1   <= '0;
            tmask_p1 <= '0;
            pc_p1    <= '0;
        end else begin
            if (load_p0) begin
                vld_p1   <= sel_vld_p0;
                wid_p1   <= sel_wid_p0;
                tmask_p1 <= tmask_r[sel_wid_p0];
                pc_p1    <= pc_r[sel_wid_p0];
            end
            if (grant_p0) begin
                stalled[sel_wid_p0] <= 1'b1;
                pc_r[sel_wid_p0]    <= pc_r[sel_wid_p0] + 32'd4;
                rr_ptr              <= sel_wid_p0;
            end
            if (ctl_valid) begin
                case (ctl_op)
                    OP_TMC: begin
                        tmask_r[ctl_wid] <= ctl_tmask;
                        active[ctl_wid]  <= (ctl_tmask != '0);
                    end
                    OP_WSPAWN: begin
                        active <= ctl_wmask | {{(NUM_WARPS-1){1'b0}}, active[0]};
                        for (int i = 1; i < NUM_WARPS; i++) begin
                            if (ctl_wmask[i]) begin
                                pc_r[i]    <= ctl_pc;
                                tmask_r[i] <= {{(NUM_THREADS-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    OP_BARRIER: begin
                        if (bar_release) begin
                            bar_mask[ctl_bar_id] <= '0;
                        end else begin
                            bar_mask[ctl_bar_id][ctl_wid] <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                stalled[ctl_wid] <= 1'b0;
            end
            if (br_valid) begin
                if (br_taken) begin
                    pc_r[br_wid] <= br_dest;
                end
                stalled[br_wid] <= 1'b0;
            end
            if (wstall_valid) begin
                stalled[wstall_wid] <= wstall_stalled;
            end
        end
    end

    assign req.req_valid = vld_p1;
    assign req.req_wid   = wid_p1;
    assign req.req_tmask = tmask_p1;
    assign req.req_pc    = pc_p1;
    assign active_warps  = active;
    assign busy          = |active;
endmodule

// File: doc/warp_sched_rr.md
Name: warp_sched_rr

Overview:
- Parametrised next-generation warp scheduler for the core front end.
- Tracks per-warp active, stalled and barrier state, PC and thread mask.
- Selects one ready warp per cycle, by fixed priority or round-robin (set by parameter).
- Presents the selected warp on a registered valid/ready fetch-request port; sits between the warp-control/branch/writeback feedback paths and the instruction fetch stage.

Parameters:
- NUM_WARPS, 4, warp count (power of two, ≥2); NW_BITS = log2(NUM_WARPS).
- NUM_THREADS, 4, threads per warp.
- NUM_BARRIERS, 4, barrier count (power of two); NB_BITS = max(1, log2(NUM_BARRIERS)).
- STARTUP_ADDR, 32'h80000000, reset PC of warp 0.
- SCHED_MODE, 1, 0 = lowest-index fixed priority, 1 = round-robin.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ctl_valid  in  1  warp-control command strobe
- ctl_op  in  2  0=TMC, 1=WSPAWN, 2=BARRIER, 3=reserved (ignored, still unstalls ctl_wid)
- ctl_wid  in  NW_BITS  issuing warp
- ctl_tmask  in  NUM_THREADS  TMC new thread mask
- ctl_wmask  in  NUM_WARPS  WSPAWN warp mask
- ctl_pc  in  32  WSPAWN start PC
- ctl_bar_id  in  NB_BITS  barrier id
- ctl_bar_size_m1  in  NW_BITS  barrier participant count minus one
- br_valid  in  1  branch resolution strobe
- br_wid  in  NW_BITS  branch warp
- br_taken  in  1  branch taken
- br_dest  in  32  branch target
- wstall_valid  in  1  decode stall-update strobe
- wstall_wid  in  NW_BITS  warp to update
- wstall_stalled  in  1  new stall value
- req_valid  out  1  fetch request valid
- req_ready  in  1  fetch stage accepts
- req_wid  out  NW_BITS  scheduled warp
- req_tmask  out  NUM_THREADS  scheduled thread mask
- req_pc  out  32  scheduled PC
- active_warps  out  NUM_WARPS  active warp vector
- busy  out  1  active_warps != 0

Behaviour:
- Reset (async assert, released synchronously by the surrounding reset logic):
  - active = 1; pc[0] = STARTUP_ADDR; tmask[0] = all ones.
  - pc/tmask of all other warps = 0; stalled = 0; barrier masks = 0; RR pointer = NUM_WARPS-1.
  - req_valid = 0, req_wid/req_tmask/req_pc = 0; busy = 1.
- ready = active & ~stalled & ~(OR of all barrier masks).
- Selection:
  - SCHED_MODE 0: lowest set bit of ready.
  - SCHED_MODE 1: first set bit strictly after the RR pointer, wrapping modulo NUM_WARPS; pointer <= granted wid on every grant.
- Output register:
  - load = !req_valid || req_ready.
  - On load: req_valid <= |ready; payload <= {wid, tmask[wid], pc[wid]}.
  - While req_valid && !req_ready: outputs held stable and no grant occurs.
- Grant (load && |ready):
  - stalled[wid] <= 1; pc[wid] <= pc[wid] + 4 (mod 2^32).
  - Latency from ready to req_valid is 1 cycle.
- TMC: tmask[wid] <= ctl_tmask; active[wid] <= (ctl_tmask != 0); stalled[wid] <= 0.
- WSPAWN:
  - active <= ctl_wmask | active[0]. Warp 0 is never deactivated by WSPAWN.
  - Each warp i ≠ 0 with wmask[i]=1: pc <= ctl_pc, tmask <= 1.
  - stalled[ctl_wid] <= 0.
- BARRIER:
  - cnt = popcount(barrier_mask[id]).
  - If cnt == size_m1: mask[id] <= 0, releasing all waiters; size_m1 = 0 releases at once.
  - Otherwise mask[id][wid] <= 1.
  - stalled[wid] <= 0.
- Branch: if taken, pc[br_wid] <= br_dest; stalled[br_wid] <= 0.
- wstall: stalled[wstall_wid] <= wstall_stalled.
- Same-cycle write precedence, lowest to highest:
  - stalled: grant set, ctl clear, branch clear, wstall.
  - pc: grant +4, WSPAWN, branch.
  - tmask: WSPAWN, TMC.
- Reset asserted mid-request drops req_valid immediately, with no handshake completion.

Test Plan:
- Release reset, req_ready=1 → cycle 1: req_valid=1, wid=0, pc=0x80000000, tmask=4'hF; then req_valid=0 until warp 0 is unstalled.
- Branch taken wid0 dest=0x80000100 → next grant has pc=0x80000100; not-taken → pc=0x80000004.
- WSPAWN wmask=4'hF pc=0x80001000, SCHED_MODE=1, wstall clears each cycle → wids granted 1,2,3,0,1…; warps 1–3 show tmask=4'h1, pc=0x80001000. With SCHED_MODE=0 → wid 0 repeatedly.
- Barrier id=0 size_m1=2 from wids 1 then 2 → both excluded from grants; third from wid 3 → mask cleared, wids 1 and 2 granted again.
- Hold req_ready=0 two cycles with warps ready → req_* unchanged, no pc increments; on ready=1, next warp loads.
- TMC wid0 tmask=0 with other warps inactive → active_warps=0, busy=0, req_valid=0; assert reset mid-request → req_valid=0 asynchronously.
